data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory for the single-cycle RISC-V core.
// This block models a slow memory with a fixed number of wait states. The
// controller stalls the PC while busy is high.
//
// Build option: define DMEM_ERR_EN to reject illegal requests and to add the
// err port. Illegal requests are a misaligned address or read+write together.
//
// Ports:
//   clock, reset   clock; synchronous active-high reset
//   MemRead        read request (held by the controller while busy)
//   MemWrite       write request (held by the controller while busy)
//   addr           byte address; word index = addr[$clog2(DEPTH)+1:2]
//   wdata          store data, committed at the clock edge that ends DONE
//   rdata          registered load data; holds until the next completed read
//   busy           access in progress; combinational in the accept cycle
//   err            (DMEM_ERR_EN only) illegal request rejected this cycle
module data_mem_ctrl #(
  parameter int NBITS       = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy
`ifdef DMEM_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] rdata_q, rdata_d;
  logic [NBITS-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    idx;
  logic             req;
  logic             rd_only;

  // Upper address bits wrap. The low two bits only matter for the error check.
  assign idx     = addr[AW+1:2];
  assign req     = MemRead | MemWrite;
  assign rd_only = MemRead & ~MemWrite;   // write wins when both are high

  logic unused_addr;
  assign unused_addr = ^addr;

`ifdef DMEM_ERR_EN
  logic illegal;
  assign illegal = (addr[1:0] != 2'b00) | (MemRead & MemWrite);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    busy    = 1'b0;
`ifdef DMEM_ERR_EN
    err     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
`ifdef DMEM_ERR_EN
          if (illegal) err = 1'b1;
          else
`endif
          begin
            busy    = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        // If the controller drops the request, the access is abandoned
        // and rdata is left untouched.
        if (!req)                state_d = S_IDLE;
        else if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
        else begin
          if (rd_only) rdata_d = mem_q[idx];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The PC advances at this edge, so the store commits here too.
        // A request dropped in DONE has MemWrite low and writes nothing.
        mem_we  = MemWrite;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset aborts any in-flight access and suppresses its write.
    if (reset) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      rdata_d = '0;
      mem_we  = 1'b0;
      busy    = 1'b0;
`ifdef DMEM_ERR_EN
      err     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rdata_q <= rdata_d;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl. dut0 uses WAIT_CYCLES=2 and dut1 uses
// WAIT_CYCLES=1. The reference model is a word array plus the last value
// loaded, indexed by address/4 modulo 64. Each access is expected to show
// WAIT_CYCLES+1 busy cycles and then one DONE cycle.
module tb_data_mem_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [7:0] a0 = '0, wd0 = '0, a1 = '0, wd1 = '0;
  logic [7:0] rdata0, rdata1;
  logic       busy0, busy1;
`ifdef DMEM_ERR_EN
  logic       err0, unused_err1;
`endif

  always #5 clock = ~clock;

  data_mem_ctrl #(.NBITS(8), .DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .clock(clock), .reset(reset), .MemRead(rd0), .MemWrite(wr0),
    .addr(a0), .wdata(wd0), .rdata(rdata0), .busy(busy0)
`ifdef DMEM_ERR_EN
    , .err(err0)
`endif
  );

  data_mem_ctrl #(.NBITS(8), .DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(reset), .MemRead(rd1), .MemWrite(wr1),
    .addr(a1), .wdata(wd1), .rdata(rdata1), .busy(busy1)
`ifdef DMEM_ERR_EN
    , .err(unused_err1)
`endif
  );

  int nchk = 0;
  int nerr = 0;
  logic [7:0] mem_m [2][64];
  logic [7:0] rd_m  [2];

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp;   // rdata expected in the DONE cycle
    string      nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit s, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] wd);
    if (s) begin rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; end
    else   begin rd0 = rd; wr0 = wr; a0 = a; wd0 = wd; end
  endtask

  function automatic logic get_busy(input bit s);
    return s ? busy1 : busy0;
  endfunction

  function automatic logic [7:0] get_rdata(input bit s);
    return s ? rdata1 : rdata0;
  endfunction

  // Full access, starting just after a rising edge. The task drops the
  // request just after the edge that ends DONE.
  task automatic access(input bit s, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] wd,
                        input string nm, output logic [7:0] got);
    int w;
    w = s ? 1 : 2;
    drive(s, rd, wr, a, wd);
    for (int k = 0; k <= w; k++) begin
      @(negedge clock);
      chk({nm, " busy"}, 8'(get_busy(s)), 8'd1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk({nm, " done busy"}, 8'(get_busy(s)), 8'd0);
    if (rd && !wr) rd_m[s] = mem_m[s][a[7:2]];
    got = get_rdata(s);
    chk({nm, " rdata"}, got, rd_m[s]);
    @(posedge clock); #1;
    if (wr) mem_m[s][a[7:2]] = wd;
    drive(s, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic idle(input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk("idle busy", 8'(get_busy(s)), 8'd0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [7:0] got;
    bit         s;
    int         op;
    logic [7:0] ra, rw;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    rd_m[0] = 8'h00; rd_m[1] = 8'h00;
    @(negedge clock);
    chk("reset busy0", 8'(busy0), 8'd0);
    chk("reset rdata0", rdata0, 8'h00);
    chk("reset busy1", 8'(busy1), 8'd0);
    chk("reset rdata1", rdata1, 8'h00);
    @(posedge clock); #1;

    // Fill both memories so that every later read has a defined value.
    for (int i = 0; i < 64; i++) begin
      access(1'b0, 1'b0, 1'b1, 8'(i * 4), 8'(i * 7 + 3), "init0", got);
      access(1'b1, 1'b0, 1'b1, 8'(i * 4), 8'(i ^ 8'h5A), "init1", got);
    end

    // Table-driven vectors on dut0.
    tbl.push_back('{1'b0, 1'b1, 8'd12, 8'hA5, 8'h00, "wr12"});
    tbl.push_back('{1'b1, 1'b0, 8'd12, 8'h00, 8'hA5, "rd12"});
    tbl.push_back('{1'b0, 1'b1, 8'd20, 8'h3C, 8'hA5, "wr20"});
    tbl.push_back('{1'b1, 1'b0, 8'd20, 8'h00, 8'h3C, "rd20"});
    tbl.push_back('{1'b1, 1'b0, 8'(20 + 4 * 64), 8'h00, 8'h3C, "rd20wrap"});
`ifndef DMEM_ERR_EN
    tbl.push_back('{1'b1, 1'b1, 8'd40, 8'h77, 8'h3C, "rdwr40"});
    tbl.push_back('{1'b1, 1'b0, 8'd40, 8'h00, 8'h77, "rd40"});
    tbl.push_back('{1'b1, 1'b0, 8'd13, 8'h00, 8'hA5, "rd13unaligned"});
`endif
    foreach (tbl[i]) begin
      access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].nm, got);
      chk({tbl[i].nm, " table"}, got, tbl[i].exp);
    end

    // Abort: write FF at addr 8 and drop the request in cycle 1.
    drive(1'b0, 1'b0, 1'b1, 8'd8, 8'hFF);
    @(negedge clock); chk("abort c0 busy", 8'(busy0), 8'd1);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd8, 8'hFF);
    @(negedge clock); chk("abort c1 busy", 8'(busy0), 8'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort c2 busy", 8'(busy0), 8'd0);
    chk("abort rdata", rdata0, rd_m[0]);
    @(posedge clock); #1;
    access(1'b0, 1'b1, 1'b0, 8'd8, 8'h00, "abort rd8", got);
    chk("abort old value", got, 8'(2 * 7 + 3));

    // Reset in cycle 2 of a write of 11 to addr 4.
    drive(1'b0, 1'b0, 1'b1, 8'd4, 8'h11);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rd_m[0] = 8'h00; rd_m[1] = 8'h00;
    @(negedge clock);
    chk("rst mid busy", 8'(busy0), 8'd0);
    chk("rst mid rdata", rdata0, 8'h00);
    @(posedge clock); #1;
    access(1'b0, 1'b1, 1'b0, 8'd4, 8'h00, "rst rd4", got);
    chk("rst mem1 kept", got, 8'(1 * 7 + 3));

    // Back-to-back reads on dut1 (WAIT_CYCLES=1): busy 1,1,0,1,1,0.
    access(1'b1, 1'b1, 1'b0, 8'd0, 8'h00, "b2b rd0", got);
    chk("b2b rd0 value", got, 8'h5A);
    access(1'b1, 1'b1, 1'b0, 8'd4, 8'h00, "b2b rd4", got);
    chk("b2b rd4 value", got, 8'h5B);
    idle(1'b1, 1);

`ifdef DMEM_ERR_EN
    // Illegal requests are rejected in IDLE with no state change.
    drive(1'b0, 1'b1, 1'b0, 8'd13, 8'h00);
    @(negedge clock);
    chk("err unaligned err", 8'(err0), 8'd1);
    chk("err unaligned busy", 8'(busy0), 8'd0);
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b1, 8'd16, 8'h99);
    @(negedge clock);
    chk("err rdwr err", 8'(err0), 8'd1);
    chk("err rdwr busy", 8'(busy0), 8'd0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    chk("err cleared", 8'(err0), 8'd0);
    chk("err rdata kept", rdata0, rd_m[0]);
    @(posedge clock); #1;
    access(1'b0, 1'b1, 1'b0, 8'd16, 8'h00, "err rd16", got);
    chk("err no write", got, 8'(4 * 7 + 3));
`endif

    // Random accesses on both instances against the model.
    for (int n = 0; n < 200; n++) begin
      s  = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      ra = 8'($urandom);
      rw = 8'($urandom);
`ifdef DMEM_ERR_EN
      ra[1:0] = 2'b00;
      if (op == 2) op = 1;
`endif
      access(s, op != 1, op != 0, ra, rw, "rand", got);
      idle(s, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
